// File: rtl/f2s_burst_arbiter.sv
// f2s_burst_arbiter
// Two-master, burst-locked round-robin arbiter in front of the HPS
// FPGA-to-SDRAM Avalon-MM port. Ownership is held for a complete burst,
// including every returned read beat, so read data can never be misrouted.
// Optional build macro: F2S_ARB_STATS_EN adds per-master completed-burst
// counters (m0_burst_cnt, m1_burst_cnt).
module f2s_burst_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int BC_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // master 0
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [BC_W-1:0]       m0_burstcount,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [BC_W-1:0]       m1_burstcount,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  // shared f2s port
  output logic [ADDR_W-1:0]     f2s_address,
  output logic [BC_W-1:0]       f2s_burstcount,
  output logic                  f2s_read,
  output logic                  f2s_write,
  output logic [DATA_W-1:0]     f2s_writedata,
  output logic [DATA_W/8-1:0]   f2s_byteenable,
  input  logic                  f2s_waitrequest,
  input  logic [DATA_W-1:0]     f2s_readdata,
  input  logic                  f2s_readdatavalid
`ifdef F2S_ARB_STATS_EN
  ,
  output logic [31:0]           m0_burst_cnt,
  output logic [31:0]           m1_burst_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_CMD   = 2'd2,
    RD_DATA  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 0 = m0, 1 = m1
  logic              prio_q, prio_d;     // master favoured on a tie
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BC_W-1:0]   burst_len_q, burst_len_d;
  logic [BC_W-1:0]   rd_rem_q, rd_rem_d;
  logic              burst_done;

  logic              req0, req1, grant, grant_wr;
  logic [ADDR_W-1:0] sel_address;
  logic [BC_W-1:0]   sel_burstcount;
  logic              sel_read, sel_write;
  logic [DATA_W-1:0] sel_writedata;
  logic [DATA_W/8-1:0] sel_byteenable;
  logic              wr_acc, rd_acc, owner_wait;
  logic [BC_W-1:0]   wr_len;

  // A burstcount of zero means a single beat
  function automatic logic [BC_W-1:0] bc_eff(input logic [BC_W-1:0] bc);
    return (bc == '0) ? BC_W'(1) : bc;
  endfunction

  // Owner-selected master signals and arbitration decision
  always_comb begin
    sel_address    = owner_q ? m1_address    : m0_address;
    sel_burstcount = owner_q ? m1_burstcount : m0_burstcount;
    sel_read       = owner_q ? m1_read       : m0_read;
    sel_write      = owner_q ? m1_write      : m0_write;
    sel_writedata  = owner_q ? m1_writedata  : m0_writedata;
    sel_byteenable = owner_q ? m1_byteenable : m0_byteenable;
    req0           = m0_read | m0_write;
    req1           = m1_read | m1_write;
    grant          = (req0 && req1) ? prio_q : req1;
    grant_wr       = grant ? m1_write : m0_write;
    wr_acc         = (state_q == WR_BURST) && sel_write && !f2s_waitrequest;
    rd_acc         = (state_q == RD_CMD) && sel_read && !f2s_waitrequest;
    // Length comes from the first accepted beat; later beats use the latch
    wr_len         = (beat_cnt_q == '0) ? bc_eff(sel_burstcount) : burst_len_q;
  end

  // State, owner, pointer and beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
      rd_rem_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_len_q <= burst_len_d;
      rd_rem_q    <= rd_rem_d;
    end
  end

  // Next-state logic and all port-facing outputs
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    prio_d           = prio_q;
    beat_cnt_d       = beat_cnt_q;
    burst_len_d      = burst_len_q;
    rd_rem_d         = rd_rem_q;
    burst_done       = 1'b0;
    owner_wait       = 1'b1;
    f2s_address      = '0;
    f2s_burstcount   = '0;
    f2s_read         = 1'b0;
    f2s_write        = 1'b0;
    f2s_writedata    = '0;
    f2s_byteenable   = '0;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;

    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (req0 || req1) begin
          owner_d = grant;
          state_d = grant_wr ? WR_BURST : RD_CMD;
        end
      end

      WR_BURST: begin
        f2s_address    = sel_address;
        f2s_burstcount = sel_burstcount;
        f2s_write      = sel_write;
        f2s_writedata  = sel_writedata;
        f2s_byteenable = sel_byteenable;
        owner_wait     = f2s_waitrequest;
        if (wr_acc) begin
          if (beat_cnt_q == '0) burst_len_d = wr_len;
          if (beat_cnt_q == wr_len - BC_W'(1)) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
            prio_d     = ~owner_q;
            burst_done = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + BC_W'(1);
          end
        end
      end

      RD_CMD: begin
        f2s_address    = sel_address;
        f2s_burstcount = sel_burstcount;
        f2s_read       = sel_read;
        owner_wait     = f2s_waitrequest;
        if (rd_acc) begin
          rd_rem_d = bc_eff(sel_burstcount);
          state_d  = RD_DATA;
        end
      end

      RD_DATA: begin
        if (f2s_readdatavalid) begin
          if (owner_q) m1_readdatavalid = 1'b1;
          else         m0_readdatavalid = 1'b1;
          rd_rem_d = rd_rem_q - BC_W'(1);
          if (rd_rem_q == BC_W'(1)) begin
            state_d    = IDLE;
            prio_d     = ~owner_q;
            burst_done = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    m0_waitrequest = owner_q ? 1'b1 : owner_wait;
    m1_waitrequest = owner_q ? owner_wait : 1'b1;
  end

  // Read data is broadcast; only readdatavalid is owner-qualified
  always_comb begin
    m0_readdata = f2s_readdata;
    m1_readdata = f2s_readdata;
  end

`ifdef F2S_ARB_STATS_EN
  // Completed-burst counters, credited to the owner of the finishing burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_burst_cnt <= '0;
      m1_burst_cnt <= '0;
    end else if (burst_done) begin
      if (owner_q) m1_burst_cnt <= m1_burst_cnt + 32'd1;
      else         m0_burst_cnt <= m0_burst_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_f2s_burst_arbiter.sv
// Self-checking bench for f2s_burst_arbiter: directed write/read bursts,
// arbitration order, readdatavalid gaps, zero burstcount and mid-burst
// reset, with write beats and read data tracked through scoreboard queues.
// Build with F2S_ARB_STATS_EN defined to also check the burst counters.
module tb_f2s_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] m_address [2];
  logic [7:0]  m_bc [2];
  logic        m_read [2];
  logic        m_write [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_be [2];
  logic        m_wait [2];
  logic [31:0] m_rdata [2];
  logic        m_rdv [2];
  logic [29:0] f2s_address;
  logic [7:0]  f2s_burstcount;
  logic        f2s_read, f2s_write;
  logic [31:0] f2s_writedata;
  logic [3:0]  f2s_byteenable;
  logic        f2s_waitrequest;
  logic [31:0] f2s_readdata;
  logic        f2s_readdatavalid;
`ifdef F2S_ARB_STATS_EN
  logic [31:0] m0_burst_cnt, m1_burst_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [61:0] wr_q [$];   // {address, writedata} per expected beat
  logic [31:0] rd_q [$];   // expected read data per returned beat

  always #5 clk = ~clk;

  f2s_burst_arbiter #(.ADDR_W(30), .DATA_W(32), .BC_W(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .m0_address        (m_address[0]),
    .m0_burstcount     (m_bc[0]),
    .m0_read           (m_read[0]),
    .m0_write          (m_write[0]),
    .m0_writedata      (m_wdata[0]),
    .m0_byteenable     (m_be[0]),
    .m0_waitrequest    (m_wait[0]),
    .m0_readdata       (m_rdata[0]),
    .m0_readdatavalid  (m_rdv[0]),
    .m1_address        (m_address[1]),
    .m1_burstcount     (m_bc[1]),
    .m1_read           (m_read[1]),
    .m1_write          (m_write[1]),
    .m1_writedata      (m_wdata[1]),
    .m1_byteenable     (m_be[1]),
    .m1_waitrequest    (m_wait[1]),
    .m1_readdata       (m_rdata[1]),
    .m1_readdatavalid  (m_rdv[1]),
    .f2s_address       (f2s_address),
    .f2s_burstcount    (f2s_burstcount),
    .f2s_read          (f2s_read),
    .f2s_write         (f2s_write),
    .f2s_writedata     (f2s_writedata),
    .f2s_byteenable    (f2s_byteenable),
    .f2s_waitrequest   (f2s_waitrequest),
    .f2s_readdata      (f2s_readdata),
    .f2s_readdatavalid (f2s_readdatavalid)
`ifdef F2S_ARB_STATS_EN
    ,
    .m0_burst_cnt      (m0_burst_cnt),
    .m1_burst_cnt      (m1_burst_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      m_address[i] = '0; m_bc[i] = '0; m_read[i] = 1'b0; m_write[i] = 1'b0;
      m_wdata[i] = '0; m_be[i] = '0;
    end
    f2s_waitrequest = 1'b0; f2s_readdata = '0; f2s_readdatavalid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_inputs();
    wr_q.delete();
    rd_q.delete();
    @(negedge clk);
    check("rst_f2s_write", f2s_write, 0);
    check("rst_f2s_read", f2s_read, 0);
    check("rst_f2s_addr", f2s_address, 0);
    check("rst_f2s_bc", f2s_burstcount, 0);
    check("rst_f2s_wdata", f2s_writedata, 0);
    check("rst_f2s_be", f2s_byteenable, 0);
    check("rst_m0_wait", m_wait[0], 1);
    check("rst_m1_wait", m_wait[1], 1);
    check("rst_m0_rdv", m_rdv[0], 0);
    check("rst_m1_rdv", m_rdv[1], 0);
`ifdef F2S_ARB_STATS_EN
    check("rst_m0_cnt", m0_burst_cnt, 0);
    check("rst_m1_cnt", m1_burst_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] wdata_of(input int m, input logic [29:0] addr, input int beat);
    return (32'(m + 1) << 28) | (32'(addr) << 8) | 32'(beat);
  endfunction

  task automatic present_write(input int m, input logic [29:0] addr, input logic [7:0] bc);
    m_address[m] = addr;
    m_bc[m]      = bc;
    m_be[m]      = (m == 1) ? 4'h3 : 4'hF;
    m_wdata[m]   = wdata_of(m, addr, 0);
    m_write[m]   = 1'b1;
  endtask

  // One IDLE turnaround cycle: nothing issued, both masters stalled
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_f2s_write"}, f2s_write, 0);
    check({tag, "_f2s_read"}, f2s_read, 0);
    check({tag, "_m0_wait"}, m_wait[0], 1);
    check({tag, "_m1_wait"}, m_wait[1], 1);
    @(posedge clk); #1;
  endtask

  // Master m issues a write burst; starts in a cycle where the DUT is IDLE
  task automatic serve_write(input int m, input logic [29:0] addr, input logic [7:0] bc,
                             input int nbeats, input bit gap, input bit stall);
    int beats = 0;
    int cyc = 0;
    bit gapped = 1'b0;
    bit acc;
    int o = 1 - m;
    logic [61:0] e;
    present_write(m, addr, bc);
    wr_q.push_back({addr, wdata_of(m, addr, 0)});
    f2s_waitrequest = 1'b0;
    @(negedge clk);
    check("wr_arb_cycle_write", f2s_write, 0);
    check("wr_arb_cycle_wait", m_wait[m], 1);
    @(posedge clk); #1;
    while (beats < nbeats && cyc < 64) begin
      f2s_waitrequest = stall && (cyc == 1);
      if (gap && beats == 2 && !gapped) begin
        m_write[m] = 1'b0;
        gapped = 1'b1;
      end else begin
        m_write[m] = 1'b1;
      end
      @(negedge clk);
      if (cyc == 0) check("wr_first_beat_latency", f2s_write, 1);
      check("wr_f2s_write", f2s_write, m_write[m]);
      check("wr_other_wait", m_wait[o], 1);
      check("wr_owner_wait", m_wait[m], f2s_waitrequest);
      acc = m_write[m] && !f2s_waitrequest;
      if (acc) begin
        check("wr_sb_nonempty", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          check("wr_addr", f2s_address, e[61:32]);
          check("wr_data", f2s_writedata, e[31:0]);
          check("wr_bc", f2s_burstcount, bc);
          check("wr_be", f2s_byteenable, (m == 1) ? 4'h3 : 4'hF);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        beats++;
        if (beats < nbeats) begin
          m_wdata[m] = wdata_of(m, addr, beats);
          wr_q.push_back({addr, wdata_of(m, addr, beats)});
        end
      end
    end
    m_write[m] = 1'b0;
    f2s_waitrequest = 1'b0;
    check("wr_beats_done", beats, nbeats);
  endtask

  // Master m issues a read burst; bench acts as the SDRAM side
  task automatic serve_read(input int m, input logic [29:0] addr, input logic [7:0] bc,
                            input int nbeats, input bit gappy);
    int o = 1 - m;
    int cyc = 0;
    int k = 0;
    int got = 0;
    bit done = 1'b0;
    bit v;
    logic [31:0] e;
    m_address[m] = addr;
    m_bc[m]      = bc;
    m_read[m]    = 1'b1;
    while (!done && cyc < 32) begin
      f2s_waitrequest = (cyc == 1);
      @(negedge clk);
      check("rd_cmd_other_wait", m_wait[o], 1);
      if (f2s_read === 1'b1) begin
        check("rd_cmd_addr", f2s_address, addr);
        check("rd_cmd_bc", f2s_burstcount, bc);
        check("rd_cmd_owner_wait", m_wait[m], f2s_waitrequest);
        if (!f2s_waitrequest) done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("rd_cmd_accepted", done, 1);
    m_read[m] = 1'b0;
    f2s_waitrequest = 1'b0;
    while (got < nbeats && k < 64) begin
      v = gappy ? (k % 3 != 1) : 1'b1;
      f2s_readdatavalid = v;
      f2s_readdata = $urandom;
      if (v) rd_q.push_back(f2s_readdata);
      @(negedge clk);
      check("rd_owner_rdv", m_rdv[m], v);
      check("rd_other_rdv", m_rdv[o], 0);
      check("rd_owner_wait", m_wait[m], 1);
      check("rd_f2s_read", f2s_read, 0);
      if (v) begin
        check("rd_sb_nonempty", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          check("rd_owner_data", m_rdata[m], e);
          check("rd_other_data", m_rdata[o], e);
        end
      end
      @(posedge clk); #1;
      k++;
      if (v) got++;
    end
    f2s_readdatavalid = 1'b0;
    check("rd_beats_done", got, nbeats);
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    @(posedge clk); #1;

    // m0 4-beat write to 0x100, no stalls
    reset_dut();
    serve_write(0, 30'h100, 8'd4, 4, 1'b0, 1'b0);
    idle_check("wr4_idle");
    // m1 write with a slave stall and a write=0 gap mid-burst
    serve_write(1, 30'h200, 8'd4, 4, 1'b1, 1'b1);
    idle_check("wrgap_idle");

    // Simultaneous 8-beat reads after reset: m0 first, then m1
    reset_dut();
    m_address[1] = 30'h500; m_bc[1] = 8'd8; m_read[1] = 1'b1;
    serve_read(0, 30'h400, 8'd8, 8, 1'b0);
    serve_read(1, 30'h500, 8'd8, 8, 1'b0);
    idle_check("rd2_idle");

    // m1 8-beat read with readdatavalid gaps
    serve_read(1, 30'h600, 8'd8, 8, 1'b1);
    idle_check("rdgap_idle");

    // Burstcount 0 write is one beat; pending m1 read is granted next
    reset_dut();
    m_address[1] = 30'h700; m_bc[1] = 8'd2; m_read[1] = 1'b1;
    serve_write(0, 30'h800, 8'd0, 1, 1'b0, 1'b0);
    idle_check("bc0_idle");
    serve_read(1, 30'h700, 8'd2, 2, 1'b0);
    idle_check("bc0_rd_idle");

    // Reset asserted during beat 2 of a 4-beat write
    reset_dut();
    present_write(0, 30'h900, 8'd4);
    @(posedge clk); #1;            // arbitration edge
    @(posedge clk); #1;            // beat 0 accepted
    @(posedge clk); #1;            // beat 1 accepted
    @(negedge clk);
    check("midrst_pre_write", f2s_write, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_write_drop", f2s_write, 0);
    check("midrst_m0_wait", m_wait[0], 1);
    check("midrst_m1_wait", m_wait[1], 1);
    m_write[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Both request after reset: m0 favoured, then m1
    present_write(1, 30'hA00, 8'd2);
    serve_write(0, 30'hB00, 8'd3, 3, 1'b0, 1'b0);
    serve_write(1, 30'hA00, 8'd2, 2, 1'b0, 1'b0);
    idle_check("post_rst_idle");
    serve_read(0, 30'hC00, 8'd2, 2, 1'b0);
    idle_check("cnt_idle0");
    serve_read(1, 30'hD00, 8'd3, 3, 1'b1);
    idle_check("cnt_idle1");
    serve_write(0, 30'hE00, 8'd2, 2, 1'b0, 1'b0);
    idle_check("cnt_idle2");
`ifdef F2S_ARB_STATS_EN
    check("stats_m0_cnt", m0_burst_cnt, 3);
    check("stats_m1_cnt", m1_burst_cnt, 2);
`endif
    check("wr_sb_drained", wr_q.size(), 0);
    check("rd_sb_drained", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/f2s_burst_arbiter.md
# f2s_burst_arbiter

Two-master, burst-locked round-robin arbiter sharing the HPS FPGA-to-SDRAM Avalon-MM port (avalon_f2s_*: 30-bit word address, 8-bit burstcount, 32-bit data) between CNN engine requesters. A typical pairing is the feature-map reader and the result writer. It sits between the engine masters and the soc_system f2s conduit. Ownership is held for a whole burst, including all read-data beats, so returned data is never misrouted.

## Interface
Parameters:
- ADDR_W, 30, word address width (matches avalon_f2s_address)
- DATA_W, 32, data width
- BC_W, 8, burstcount width

Ports:
- clk  in  1  system clock, same domain as avalon_clk_clk
- rst_n  in  1  asynchronous active-low reset
- mN_address  in  ADDR_W  master N address (N = 0, 1)
- mN_burstcount  in  BC_W  master N burst length in beats
- mN_read, mN_write  in  1  master N commands
- mN_writedata  in  DATA_W  master N write data
- mN_byteenable  in  DATA_W/8  master N byte enables
- mN_waitrequest  out  1  stall to master N
- mN_readdata  out  DATA_W  read data (broadcast to both masters)
- mN_readdatavalid  out  1  read beat valid, owner only
- f2s_address, f2s_burstcount, f2s_read, f2s_write, f2s_writedata, f2s_byteenable  out  –  to avalon_f2s_*
- f2s_waitrequest, f2s_readdata, f2s_readdatavalid  in  –  from avalon_f2s_*

## Operation
- States: IDLE, WR_BURST, RD_CMD, RD_DATA.
- A master requests when (read | write) is high.
- IDLE:
  - If both request, grant the master that did not own the last burst.
  - If one requests, grant it.
  - Latch owner. Go to WR_BURST if the owner's write is high, else RD_CMD.
  - If a master asserts read and write together, write wins (protocol violation, not flagged).
- WR_BURST:
  - Owner's address, burstcount, write, writedata and byteenable pass combinationally to f2s_*.
  - The beat counter increments on f2s_write & !f2s_waitrequest.
  - Burst length is latched from the first accepted beat; burstcount 0 is treated as 1.
  - When the final beat is accepted: return to IDLE and flip the priority pointer.
- RD_CMD:
  - Owner's read, address and burstcount pass through.
  - On f2s_read & !f2s_waitrequest: latch remaining = burstcount (0 treated as 1), go to RD_DATA.
- RD_DATA:
  - f2s_read = 0; owner's waitrequest = 1.
  - Each f2s_readdatavalid pulses the owner's readdatavalid and decrements remaining.
  - When remaining reaches 0: go to IDLE and flip the pointer.
- Non-owner mN_waitrequest = 1 at all times. Owner mN_waitrequest = f2s_waitrequest in WR_BURST and RD_CMD.
- In IDLE, f2s_read = f2s_write = 0 and both waitrequests = 1.
- f2s_readdatavalid arriving in IDLE or WR_BURST is dropped; the upstream guarantee is that this never occurs.

## Timing
- Reset values:
  - state IDLE; pointer favours m0; counters 0.
  - f2s_read/f2s_write = 0; f2s_address/burstcount/writedata/byteenable = 0.
  - mN_waitrequest = 1; mN_readdatavalid = 0.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge k allows the first beat to reach f2s_* in cycle k+1.
- Pass-through paths are combinational, with no added pipeline. Read data has zero-cycle latency from f2s_readdata to mN_readdata.
- Turnaround: at least 1 IDLE cycle between consecutive bursts, even with the same owner.
- rst_n assertion mid-burst forces IDLE immediately and abandons the burst. The SDRAM side is reset by the same tree.
- Write beats may be non-contiguous; a gap with write = 0 keeps ownership.

## Configuration
- F2S_ARB_STATS_EN defined:
  - Adds outputs m0_burst_cnt and m1_burst_cnt, each 32-bit, reset 0.
  - Each counter increments by 1 in the cycle its master's burst completes (last write beat accepted or last read beat returned).
  - Counters wrap from 0xFFFFFFFF to 0.
- F2S_ARB_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- m0 4-beat write to 0x100 with f2s_waitrequest low → f2s_write high for 4 cycles starting 1 cycle after request; m1_waitrequest = 1 throughout; state returns to IDLE.
- m0 and m1 request reads of 8 beats in the same cycle after reset → m0 granted first, then m1; m1's readdatavalid stays 0 until m0's 8 beats have returned.
- m1 8-beat read with readdatavalid gaps (pattern 1,0,1,1,0,...) → m1 receives exactly 8 valid beats with matching readdata; no IDLE until the 8th beat.
- m0 write with burstcount 0 → exactly 1 beat issued; next grant goes to m1 if it is requesting.
- rst_n pulsed low at beat 2 of a 4-beat write → f2s_write drops asynchronously; both waitrequests = 1; the next request is served from IDLE with m0 priority.
- With F2S_ARB_STATS_EN defined: 3 m0 bursts and 2 m1 bursts → m0_burst_cnt = 3, m1_burst_cnt = 2. A counter preloaded to 0xFFFFFFFF wraps to 0.
